// File: rtl/iterative_shifter.sv
// ---------------------------------------------------------------------------
// iterative_shifter
//   Multi-cycle shift unit for the ALU/multdiv datapath. One operation is
//   accepted at a time. The unit then shifts by up to STEP positions per
//   clock until the requested amount is consumed, and presents the result
//   on a valid/ready output handshake.
//
// Parameters
//   WIDTH   : data width (power of 2, >= 2)
//   SHAMT_W : shift-amount width, 2**SHAMT_W == WIDTH
//   STEP    : max positions shifted per clock (power of 2, 1..WIDTH)
//
// Ports
//   clock     : rising-edge clock
//   reset     : asynchronous, active-low reset
//   in_valid  : operand/op/shamt presented
//   in_ready  : unit can accept an operation (IDLE)
//   data_in   : operand
//   shamt     : shift amount, 0..WIDTH-1
//   op        : 00 SLL, 01 SRL, 10 SRA, 11 ROL
//   out_valid : data_out holds a completed result (DONE)
//   out_ready : consumer takes the result
//   data_out  : result; holds the last result outside DONE
// ---------------------------------------------------------------------------
module iterative_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [1:0]         op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   data_out
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROL = 2'b11
   } op_t;

   // One extra bit so that STEP == WIDTH is representable.
   localparam int              CNT_W   = SHAMT_W + 1;
   localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP);
   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

   state_t               r_state;
   state_t               w_next_state;
   logic                 r_armed;
   logic [WIDTH-1:0]     r_work;
   logic [WIDTH-1:0]     r_result;
   logic [SHAMT_W-1:0]   r_remain;
   op_t                  r_op;
   logic                 r_sign;

   logic                 w_accept;
   logic                 w_last;
   logic [CNT_W-1:0]     w_remain_ext;
   logic [CNT_W-1:0]     w_k;
   logic [WIDTH-1:0]     w_fill_mask;
   logic [WIDTH-1:0]     w_shifted;

   // in_ready stays low until the first edge after reset release, so the
   // output is 0 throughout reset even though the state is already IDLE.
   assign in_ready  = r_armed & (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign data_out  = r_result;
   assign w_accept  = in_valid & in_ready;

   // k = min(STEP, remaining); the final step is the one that consumes the rest.
   assign w_remain_ext = {1'b0, r_remain};
   assign w_k          = (w_remain_ext < STEP_C) ? w_remain_ext : STEP_C;
   assign w_last       = (w_remain_ext <= STEP_C);

   // Ones in the k vacated MSB positions; used to sign-fill SRA.
   assign w_fill_mask = ~({WIDTH{1'b1}} >> w_k);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      w_shifted = r_work;
      case (r_op)
         OP_SLL: w_shifted = r_work << w_k;
         OP_SRL: w_shifted = r_work >> w_k;
         OP_SRA: w_shifted = (r_work >> w_k) | (w_fill_mask & {WIDTH{r_sign}});
         OP_ROL: w_shifted = (r_work << w_k) | (r_work >> (WIDTH_C - w_k));
         default: w_shifted = r_work;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)  w_next_state = (shamt == '0) ? S_DONE : S_SHIFT;
         S_SHIFT: if (w_last)    w_next_state = S_DONE;
         S_DONE:  if (out_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Datapath: working register, remaining count and presented result.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // NOTE: the working register and result are reset as well, so an
         // aborted operation can never leak a partial value onto data_out.
         r_armed  <= 1'b0;
         r_work   <= '0;
         r_result <= '0;
         r_remain <= '0;
         r_op     <= OP_SLL;
         r_sign   <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         if (w_accept) begin
            r_work   <= data_in;
            r_remain <= shamt;
            r_op     <= op_t'(op);
            r_sign   <= data_in[WIDTH-1];
            if (shamt == '0) r_result <= data_in;
         end else if (r_state == S_SHIFT) begin
            r_work   <= w_shifted;
            r_remain <= r_remain - w_k[SHAMT_W-1:0];
            if (w_last) r_result <= w_shifted;
         end
      end
   end

endmodule

// File: tb/tb_iterative_shifter.sv
// ---------------------------------------------------------------------------
// tb_iterative_shifter
//   Two instances share clock and reset: dut 0 with STEP=1, dut 1 with
//   STEP=8. A per-cycle compare process checks both against a transaction
//   level model (full-width shift operators plus a latency countdown).
//   Directed operations pin the model with hand-computed results, then both
//   units receive randomized traffic.
// ---------------------------------------------------------------------------
module tb_iterative_shifter;

   localparam int WIDTH = 32;

   logic        clock;
   logic        reset;
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic [31:0] data_in   [2];
   logic [4:0]  shamt     [2];
   logic [1:0]  op        [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [31:0] data_out  [2];

   int n_checks = 0;
   int n_fail   = 0;
   int step_of [2] = '{1, 8};

   iterative_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut0 (
      .clock(clock), .reset(reset),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .data_in(data_in[0]), .shamt(shamt[0]), .op(op[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .data_out(data_out[0])
   );

   iterative_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(8)) dut1 (
      .clock(clock), .reset(reset),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .data_in(data_in[1]), .shamt(shamt[1]), .op(op[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .data_out(data_out[1])
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting at %0t", name, $time);
   endtask

   // Reference result straight from the operation definitions.
   function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [1:0] o,
                                             input int s);
      case (o)
         2'b00:   return d << s;
         2'b01:   return d >> s;
         2'b10:   return 32'($signed(d) >>> s);
         default: return (s == 0) ? d : ((d << s) | (d >> (WIDTH - s)));
      endcase
   endfunction

   // ------------------------------------------------------------------
   // Transaction model and per-cycle compare. Inputs change just after a
   // rising edge, so at the falling edge they are exactly what the next
   // rising edge will sample.
   // ------------------------------------------------------------------
   bit          m_armed [2];
   bit          m_ready [2];
   bit          m_valid [2];
   int          m_cnt   [2];
   logic [31:0] m_res   [2];
   logic [31:0] m_data  [2];

   always @(negedge clock) begin
      for (int d = 0; d < 2; d++) begin
         check($sformatf("dut%0d in_ready", d),  32'(in_ready[d]),  32'(m_ready[d] & reset));
         check($sformatf("dut%0d out_valid", d), 32'(out_valid[d]), 32'(m_valid[d] & reset));
         check($sformatf("dut%0d data_out", d),  data_out[d],       reset ? m_data[d] : 32'h0);
         if (!reset) begin
            m_armed[d] = 1'b0;
            m_ready[d] = 1'b0;
            m_valid[d] = 1'b0;
            m_cnt[d]   = 0;
            m_data[d]  = 32'h0;
         end else if (!m_armed[d]) begin
            m_armed[d] = 1'b1;
            m_ready[d] = 1'b1;
         end else if (m_valid[d]) begin
            if (out_ready[d]) begin
               m_valid[d] = 1'b0;
               m_ready[d] = 1'b1;
            end
         end else if (m_ready[d]) begin
            if (in_valid[d]) begin
               m_ready[d] = 1'b0;
               m_res[d]   = ref_shift(data_in[d], op[d], int'(shamt[d]));
               m_cnt[d]   = (int'(shamt[d]) + step_of[d] - 1) / step_of[d];
               if (m_cnt[d] == 0) begin
                  m_valid[d] = 1'b1;
                  m_data[d]  = m_res[d];
               end
            end
         end else if (m_cnt[d] > 0) begin
            m_cnt[d]--;
            if (m_cnt[d] == 0) begin
               m_valid[d] = 1'b1;
               m_data[d]  = m_res[d];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Directed operation: present, wait for acceptance, measure latency,
   // check the result, optionally stall in DONE, then hand it off.
   // ------------------------------------------------------------------
   task automatic wait_accept(input int d, input string name, output bit ok);
      int guard = 0;
      ok = 1'b1;
      forever begin
         @(negedge clock);
         if (in_ready[d]) break;
         guard++;
         if (guard > 100) begin
            timeout_fail({name, " accept"});
            ok = 1'b0;
            break;
         end
      end
      @(posedge clock);
      #1;
      in_valid[d] = 1'b0;
      // Scrambled inputs after acceptance must not affect the result.
      data_in[d]  = $urandom;
      shamt[d]    = 5'($urandom);
      op[d]       = 2'($urandom);
   endtask

   task automatic run_op(input int d, input logic [31:0] din, input logic [1:0] o,
                         input logic [4:0] s, input int hold,
                         input logic [31:0] exp_d, input int exp_lat, input string name);
      bit ok;
      int cnt = 0;
      logic [31:0] held;
      @(posedge clock);
      #1;
      in_valid[d]  = 1'b1;
      data_in[d]   = din;
      op[d]        = o;
      shamt[d]     = s;
      out_ready[d] = 1'b0;
      wait_accept(d, name, ok);
      if (!ok) return;
      forever begin
         @(negedge clock);
         if (out_valid[d]) break;
         @(posedge clock);
         cnt++;
         if (cnt > 100) begin
            timeout_fail({name, " out_valid"});
            return;
         end
      end
      check({name, " latency"}, 32'(cnt), 32'(exp_lat));
      check({name, " result"}, data_out[d], exp_d);
      held = data_out[d];
      for (int i = 0; i < hold; i++) begin
         @(posedge clock);
         #1;
         in_valid[d] = 1'($urandom);
         data_in[d]  = $urandom;
         shamt[d]    = 5'($urandom);
      end
      if (hold > 0) begin
         @(negedge clock);
         check({name, " held out_valid"}, 32'(out_valid[d]), 32'h1);
         check({name, " held data_out"}, data_out[d], held);
         check({name, " held in_ready"}, 32'(in_ready[d]), 32'h0);
      end
      @(posedge clock);
      #1;
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      @(posedge clock);
      #1;
      out_ready[d] = 1'b0;
      check({name, " in_ready after handshake"}, 32'(in_ready[d]), 32'h1);
      check({name, " out_valid after handshake"}, 32'(out_valid[d]), 32'h0);
   endtask

   task automatic random_drive(input int d, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clock);
         #1;
         in_valid[d]  = 1'($urandom);
         data_in[d]   = $urandom;
         op[d]        = 2'($urandom);
         case ($urandom_range(0, 3))
            0:       shamt[d] = 5'd0;
            1:       shamt[d] = 5'd31;
            default: shamt[d] = 5'($urandom);
         endcase
         out_ready[d] = ($urandom_range(0, 3) != 0);
      end
      @(posedge clock);
      #1;
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
   endtask

   initial begin
      bit ok;
      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         in_valid[d]  = 1'b0;
         data_in[d]   = 32'h0;
         shamt[d]     = 5'd0;
         op[d]        = 2'b00;
         out_ready[d] = 1'b0;
      end
      #1;
      check("reset in_ready", 32'(in_ready[0]), 32'h0);
      check("reset out_valid", 32'(out_valid[0]), 32'h0);
      check("reset data_out", data_out[0], 32'h0);
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;

      // STEP=1 unit.
      run_op(0, 32'h00000001, 2'b00, 5'd31, 0, 32'h80000000, 31, "sll31");
      run_op(0, 32'h80000000, 2'b10, 5'd4,  0, 32'hF8000000, 4,  "sra4");
      run_op(0, 32'hFFFFFFFF, 2'b01, 5'd31, 0, 32'h00000001, 31, "srl31");
      run_op(0, 32'h80000001, 2'b11, 5'd1,  0, 32'h00000003, 1,  "rol1");
      run_op(0, 32'h12345678, 2'b11, 5'd8,  0, 32'h34567812, 8,  "rol8");
      run_op(0, 32'h0000F00F, 2'b10, 5'd12, 10, 32'h0000000F, 12, "sra_stall");

      // STEP=8 unit.
      run_op(1, 32'hDEADBEEF, 2'b01, 5'd17, 0, 32'h00006F56, 3, "s8 srl17");
      for (int o = 0; o < 4; o++)
         run_op(1, 32'hA5A5A5A5, 2'(o), 5'd0, 0, 32'hA5A5A5A5, 0, $sformatf("s8 op%0d sh0", o));
      run_op(1, 32'h80000000, 2'b10, 5'd31, 0, 32'hFFFFFFFF, 4, "s8 sra31");
      run_op(1, 32'h12345678, 2'b11, 5'd12, 0, 32'h45678123, 2, "s8 rol12");

      // Abort mid-shift with reset.
      @(posedge clock);
      #1;
      in_valid[0] = 1'b1;
      data_in[0]  = 32'h00000001;
      op[0]       = 2'b00;
      shamt[0]    = 5'd20;
      wait_accept(0, "abort", ok);
      repeat (4) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check("abort in_ready", 32'(in_ready[0]), 32'h0);
      check("abort out_valid", 32'(out_valid[0]), 32'h0);
      check("abort data_out", data_out[0], 32'h0);
      check("abort s8 data_out", data_out[1], 32'h0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      check("release in_ready before edge", 32'(in_ready[0]), 32'h0);
      @(posedge clock);
      #1;
      check("release in_ready after edge", 32'(in_ready[0]), 32'h1);
      run_op(0, 32'h00000003, 2'b00, 5'd2, 0, 32'h0000000C, 2, "post-reset sll2");

      // Randomized traffic on both units, checked by the compare process.
      fork
         random_drive(0, 1500);
         random_drive(1, 1500);
      join
      repeat (40) @(posedge clock);
      @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
